// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60Hz timing constants, phase encoding and colour helpers for the VGA blocks.
package vga_timing_gen_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef enum logic [1:0] {
        PHASE_ACTIVE = 2'd0,
        PHASE_FRONT  = 2'd1,
        PHASE_SYNC   = 2'd2,
        PHASE_BACK   = 2'd3
    } phase_t;

    // Colour the display blocks treat as see-through.
    localparam logic [8:0] TRANSPARENT_KEY = 9'b111101110;

    // {hsync_n, vsync_n, active} when nothing is being displayed.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    // Eight 80-pixel bars; h_hi is the column divided by 16, so each bar spans 5 steps.
    function automatic logic [8:0] bar_colour(input logic [5:0] h_hi);
        logic [8:0] colour;
        if      (h_hi < 6'd5)  colour = 9'b111111111;
        else if (h_hi < 6'd10) colour = 9'b111111000;
        else if (h_hi < 6'd15) colour = 9'b000111111;
        else if (h_hi < 6'd20) colour = 9'b000111000;
        else if (h_hi < 6'd25) colour = 9'b111000111;
        else if (h_hi < 6'd30) colour = 9'b111000000;
        else if (h_hi < 6'd35) colour = 9'b000000111;
        else                   colour = 9'b000000000;
        return colour;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster counter interface between the VGA timing generator (master) and the display stage (slave).
interface vga_timing_gen_if;

    logic       i_Enable;
    logic [9:0] o_H_Counter;
    logic [9:0] o_V_Counter;
    logic       o_HSync;
    logic       o_VSync;
    logic       o_Active;
    logic       o_Line_Start;
    logic       o_Frame_Start;
    logic [8:0] o_Pattern_Pixel;

    modport master (
        input  i_Enable,
        output o_H_Counter, o_V_Counter, o_HSync, o_VSync, o_Active,
               o_Line_Start, o_Frame_Start, o_Pattern_Pixel
    );

    modport slave (
        output i_Enable,
        input  o_H_Counter, o_V_Counter, o_HSync, o_VSync, o_Active,
               o_Line_Start, o_Frame_Start, o_Pattern_Pixel
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with its active/front/sync/back phase register.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned FRONT   = VGA_H_FRONT,
    parameter int unsigned SYNC    = VGA_H_SYNC,
    parameter int unsigned BACK    = VGA_H_BACK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [9:0] count,
    output phase_t     phase,
    output logic       wrap
);

    localparam logic [9:0] LAST_ACTIVE = 10'(VISIBLE - 1);
    localparam logic [9:0] LAST_FRONT  = 10'(VISIBLE + FRONT - 1);
    localparam logic [9:0] LAST_SYNC   = 10'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [9:0] LAST        = 10'(VISIBLE + FRONT + SYNC + BACK - 1);

    if (VISIBLE + FRONT + SYNC + BACK > 1024) begin : g_bad_total
        $error("vga_axis_counter: axis total exceeds 10-bit range");
    end

    logic [9:0] count_next;
    phase_t     phase_next;

    assign wrap = advance && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            phase <= PHASE_ACTIVE;
        end else begin
            count <= count_next;
            phase <= phase_next;
        end
    end

    // Phase changes on the cycle the counter steps onto a boundary, keeping it aligned with count.
    always_comb begin
        count_next = count;
        phase_next = phase;
        if (advance) begin
            count_next = (count == LAST) ? '0 : count + 10'd1;
            unique case (phase)
                PHASE_ACTIVE: if (count == LAST_ACTIVE) phase_next = PHASE_FRONT;
                PHASE_FRONT:  if (count == LAST_FRONT)  phase_next = PHASE_SYNC;
                PHASE_SYNC:   if (count == LAST_SYNC)   phase_next = PHASE_BACK;
                PHASE_BACK:   if (count == LAST)        phase_next = PHASE_ACTIVE;
                default:                                phase_next = PHASE_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz raster timing with SYNC_DELAY-aligned sync/active outputs.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_VISIBLE_AREA = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT_PORCH  = VGA_H_FRONT,
    parameter int unsigned H_SYNC_PULSE   = VGA_H_SYNC,
    parameter int unsigned H_BACK_PORCH   = VGA_H_BACK,
    parameter int unsigned V_VISIBLE_AREA = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT_PORCH  = VGA_V_FRONT,
    parameter int unsigned V_SYNC_PULSE   = VGA_V_SYNC,
    parameter int unsigned V_BACK_PORCH   = VGA_V_BACK,
    parameter int unsigned SYNC_DELAY     = 2
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    vga_timing_gen_if.master  bus
);

    if (SYNC_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..7");
    end

    logic       enable;
    logic [9:0] h_count;
    logic [9:0] v_count;
    phase_t     h_phase;
    phase_t     v_phase;
    logic       h_wrap;
    logic       v_wrap;
    logic [2:0] raw_sync;
    logic       line_start;

    assign enable = bus.i_Enable;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE_AREA),
        .FRONT   (H_FRONT_PORCH),
        .SYNC    (H_SYNC_PULSE),
        .BACK    (H_BACK_PORCH)
    ) u_h_axis (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .advance (enable),
        .count   (h_count),
        .phase   (h_phase),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE_AREA),
        .FRONT   (V_FRONT_PORCH),
        .SYNC    (V_SYNC_PULSE),
        .BACK    (V_BACK_PORCH)
    ) u_v_axis (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .advance (h_wrap),
        .count   (v_count),
        .phase   (v_phase),
        .wrap    (v_wrap)
    );

    frame_wrap_on_line_wrap: assert property (@(posedge i_Clk) disable iff (i_Reset) v_wrap |-> h_wrap);

    assign raw_sync = {h_phase != PHASE_SYNC,
                       v_phase != PHASE_SYNC,
                       (h_phase == PHASE_ACTIVE) && (v_phase == PHASE_ACTIVE)};

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned PIPE_W = 12;
    logic [8:0] raw_pixel;
    assign raw_pixel = raw_sync[0] ? bar_colour(h_count[9:4]) : '0;
    localparam logic [PIPE_W-1:0] IDLE_BITS = {9'd0, SYNC_IDLE};
    logic [PIPE_W-1:0] raw_bits;
    assign raw_bits = {raw_pixel, raw_sync};
`else
    localparam int unsigned PIPE_W = 3;
    localparam logic [PIPE_W-1:0] IDLE_BITS = SYNC_IDLE;
    logic [PIPE_W-1:0] raw_bits;
    assign raw_bits = raw_sync;
`endif

    logic [PIPE_W-1:0] delayed_bits;

    // Pixel travels in the same shift register as sync so both stay aligned for any depth.
    if (SYNC_DELAY == 0) begin : g_direct
        assign delayed_bits = i_Reset ? IDLE_BITS : raw_bits;
    end else begin : g_pipe
        logic [SYNC_DELAY*PIPE_W-1:0] shreg;
        logic [SYNC_DELAY*PIPE_W-1:0] shreg_next;

        if (SYNC_DELAY == 1) begin : g_one
            assign shreg_next = raw_bits;
        end else begin : g_many
            assign shreg_next = {shreg[(SYNC_DELAY-1)*PIPE_W-1:0], raw_bits};
        end

        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                shreg <= {SYNC_DELAY{IDLE_BITS}};
            end else if (enable) begin
                shreg <= shreg_next;
            end
        end

        assign delayed_bits = shreg[SYNC_DELAY*PIPE_W-1 -: PIPE_W];
    end

    assign bus.o_HSync  = delayed_bits[2];
    assign bus.o_VSync  = delayed_bits[1];
    assign bus.o_Active = delayed_bits[0];

`ifdef VGA_TEST_PATTERN_EN
    assign bus.o_Pattern_Pixel = delayed_bits[11:3];
`else
    assign bus.o_Pattern_Pixel = '0;
`endif

    assign line_start        = (h_count == '0) && enable && !i_Reset;
    assign bus.o_Line_Start  = line_start;
    assign bus.o_Frame_Start = line_start && (v_count == '0);
    assign bus.o_H_Counter   = h_count;
    assign bus.o_V_Counter   = v_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; vertical timing is shortened (13 lines) so whole frames fit the run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_VISIBLE_AREA (640),
        .H_FRONT_PORCH  (16),
        .H_SYNC_PULSE   (96),
        .H_BACK_PORCH   (48),
        .V_VISIBLE_AREA (6),
        .V_FRONT_PORCH  (2),
        .V_SYNC_PULSE   (2),
        .V_BACK_PORCH   (3),
        .SYNC_DELAY     (2)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (vif)
    );

    typedef struct {
        int rst;
        int en;
        int n;
        int h;
        int v;
        int hs;
        int vs;
        int act;
        int ls;
        int fs;
        int pix;
    } vec_t;

    localparam int WHT = 511;  // 111111111
    localparam int YEL = 504;  // 111111000
    localparam int GRN = 56;   // 000111000

    vec_t vecs[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_hs;
        int cnt_act;
        int cnt_ls;
        int cnt;
        int pix_exp;

        //                 rst en n      h    v  hs vs act ls fs pix
        vecs.push_back('{1, 1, 5,     0,   0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0,     0,   0, 1, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 1,     1,   0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     2,   0, 1, 1, 1, 0, 0, WHT});
        vecs.push_back('{0, 1, 637,   639, 0, 1, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 2,     641, 0, 1, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     642, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 15,    657, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     658, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 95,    753, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     754, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 45,    799, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     0,   1, 1, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0,     0,   1, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 10,    0,   1, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0,     0,   1, 1, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 2,     2,   1, 1, 1, 1, 0, 0, WHT});
        vecs.push_back('{0, 1, 1898,  300, 3, 1, 1, 1, 0, 0, GRN});
        vecs.push_back('{0, 0, 100,   300, 3, 1, 1, 1, 0, 0, GRN});
        vecs.push_back('{0, 1, 1,     301, 3, 1, 1, 1, 0, 0, GRN});
        vecs.push_back('{0, 1, 2099,  0,   6, 1, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 2,     2,   6, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1599,  1,   8, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     2,   8, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1599,  1,  10, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     2,  10, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 2397,  799, 12, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     0,   0, 1, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 2,     2,   0, 1, 1, 1, 0, 0, WHT});
        vecs.push_back('{0, 1, 10398, 0,   0, 1, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 7900,  700, 9, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 1,     0,   0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0,     0,   0, 1, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 1,     1,   0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1,     2,   0, 1, 1, 1, 0, 0, WHT});
        vecs.push_back('{0, 1, 100,   102, 0, 1, 1, 1, 0, 0, YEL});
        vecs.push_back('{1, 0, 1,     0,   0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0,     0,   0, 1, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 87,    87,  0, 1, 1, 1, 0, 0, YEL});
        vecs.push_back('{0, 1, 565,   652, 0, 1, 1, 0, 0, 0, 0});

        rst = 1'b1;
        vif.i_Enable = 1'b1;
        #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst[0];
            vif.i_Enable = vecs[i].en[0];
            repeat (vecs[i].n) @(posedge clk);
            #1;
`ifdef VGA_TEST_PATTERN_EN
            pix_exp = vecs[i].pix;
`else
            pix_exp = 0;
`endif
            check($sformatf("v%0d.h", i),   int'(vif.o_H_Counter),     vecs[i].h);
            check($sformatf("v%0d.v", i),   int'(vif.o_V_Counter),     vecs[i].v);
            check($sformatf("v%0d.hs", i),  int'(vif.o_HSync),         vecs[i].hs);
            check($sformatf("v%0d.vs", i),  int'(vif.o_VSync),         vecs[i].vs);
            check($sformatf("v%0d.act", i), int'(vif.o_Active),        vecs[i].act);
            check($sformatf("v%0d.ls", i),  int'(vif.o_Line_Start),    vecs[i].ls);
            check($sformatf("v%0d.fs", i),  int'(vif.o_Frame_Start),   vecs[i].fs);
            check($sformatf("v%0d.pix", i), int'(vif.o_Pattern_Pixel), pix_exp);
        end

        // One full line window from H=652,V=0: sync width, active width, single line pulse.
        cnt_hs = 0;
        cnt_act = 0;
        cnt_ls = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            if (vif.o_HSync == 1'b0) cnt_hs++;
            if (vif.o_Active == 1'b1) cnt_act++;
            if (vif.o_Line_Start == 1'b1) cnt_ls++;
        end
        check("line.hsync_low", cnt_hs, 96);
        check("line.active_high", cnt_act, 640);
        check("line.line_starts", cnt_ls, 1);
        check("line.h_after", int'(vif.o_H_Counter), 652);
        check("line.v_after", int'(vif.o_V_Counter), 1);

        // Bounded wait for the next frame start from H=652,V=1.
        cnt = 0;
        while (vif.o_Frame_Start !== 1'b1 && cnt < 20000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("frame.cycles_to_start", cnt, 8948);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
